// File: rtl/result_prev_arbiter.sv
// Two-requester arbiter feeding the previous-result storage register through an EMPTY/WRITE/FULL handshake.
// Define RESULT_PREV_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (A wins ties).
module result_prev_arbiter #(
  parameter int number_of_equations_per_cluster = 9,
  parameter int element_width                   = 32,
  parameter int count_width                     = 16,
  localparam int W = element_width * number_of_equations_per_cluster
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_a_valid,
  input  logic [W-1:0]           req_a_data,
  output logic                   req_a_ready,
  input  logic                   req_b_valid,
  input  logic [W-1:0]           req_b_data,
  output logic                   req_b_ready,
  output logic                   mem_write_enable,
  output logic [W-1:0]           mem_input_data,
  output logic                   cons_valid,
  input  logic                   cons_ready,
  output logic                   cons_src,
  output logic [count_width-1:0] write_count
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic                   mem_we_q, mem_we_d;
  logic [W-1:0]           data_q, data_d;
  logic                   src_q, src_d;
  logic [count_width-1:0] count_q, count_d;
  logic                   grant_a, grant_b, transfer;

`ifdef RESULT_PREV_ARB_RR_EN
  // Pointer 0 favours A, 1 favours B; it moves to the requester that just lost.
  logic prio_q, prio_d;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state_q == ST_EMPTY) begin
      grant_a = req_a_valid && (!req_b_valid || !prio_q);
      grant_b = req_b_valid && (!req_a_valid ||  prio_q);
    end
  end
`else
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state_q == ST_EMPTY) begin
      grant_a = req_a_valid;
      grant_b = req_b_valid && !req_a_valid;
    end
  end
`endif

  assign transfer = grant_a || grant_b;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    mem_we_d = 1'b0;
    data_d   = data_q;
    src_d    = src_q;
    count_d  = count_q;
    case (state_q)
      ST_EMPTY: begin
        if (transfer) begin
          data_d   = grant_b ? req_b_data : req_a_data;
          src_d    = grant_b;
          mem_we_d = 1'b1;
          state_d  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        count_d = count_q + count_width'(1);
        state_d = ST_FULL;
      end
      ST_FULL: begin
        if (cons_ready) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

`ifdef RESULT_PREV_ARB_RR_EN
  always_comb begin
    prio_d = prio_q;
    if (transfer) prio_d = grant_a;
  end

  always_ff @(posedge clk) begin
    if (reset) prio_q <= 1'b0;
    else       prio_q <= prio_d;
  end
`endif

  // NOTE: synchronous reset is checked first inside the clocked block, so it overrides every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      mem_we_q <= 1'b0;
      data_q   <= '0;
      src_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      mem_we_q <= mem_we_d;
      data_q   <= data_d;
      src_q    <= src_d;
      count_q  <= count_d;
    end
  end

  assign req_a_ready      = grant_a;
  assign req_b_ready      = grant_b;
  assign mem_write_enable = mem_we_q;
  assign mem_input_data   = data_q;
  assign cons_valid       = (state_q == ST_FULL);
  assign cons_src         = src_q;
  assign write_count      = count_q;

endmodule

// File: tb/tb_result_prev_arbiter.sv
// Directed self-checking bench for result_prev_arbiter; expectations follow RESULT_PREV_ARB_RR_EN when defined.
module tb_result_prev_arbiter;

  localparam int NE = 9;
  localparam int EW = 32;
  localparam int W  = NE * EW;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_a_valid, req_b_valid, cons_ready;
  logic [W-1:0]  req_a_data, req_b_data;

  logic          a_ready, b_ready, mem_we, cons_valid, cons_src;
  logic [W-1:0]  mem_data;
  logic [15:0]   wc;

  logic          a_ready2, b_ready2, mem_we2, cons_valid2, cons_src2;
  logic [W-1:0]  mem_data2;
  logic [1:0]    wc2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  result_prev_arbiter #(.number_of_equations_per_cluster(NE), .element_width(EW), .count_width(16)) dut (
    .clk(clk), .reset(reset),
    .req_a_valid(req_a_valid), .req_a_data(req_a_data), .req_a_ready(a_ready),
    .req_b_valid(req_b_valid), .req_b_data(req_b_data), .req_b_ready(b_ready),
    .mem_write_enable(mem_we), .mem_input_data(mem_data),
    .cons_valid(cons_valid), .cons_ready(cons_ready), .cons_src(cons_src),
    .write_count(wc)
  );

  result_prev_arbiter #(.number_of_equations_per_cluster(NE), .element_width(EW), .count_width(2)) dut_c2 (
    .clk(clk), .reset(reset),
    .req_a_valid(req_a_valid), .req_a_data(req_a_data), .req_a_ready(a_ready2),
    .req_b_valid(req_b_valid), .req_b_data(req_b_data), .req_b_ready(b_ready2),
    .mem_write_enable(mem_we2), .mem_input_data(mem_data2),
    .cons_valid(cons_valid2), .cons_ready(cons_ready), .cons_src(cons_src2),
    .write_count(wc2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_a_valid = 1'b0; req_b_valid = 1'b0; cons_ready = 1'b0;
    req_a_data = '0; req_b_data = '0;
    tick; tick;
    reset = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b expected 0", mem_we); end
    checks++; if (mem_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", mem_data); end
    checks++; if (cons_valid !== 1'b0) begin errors++; $display("FAIL reset_cons_valid: got %0b expected 0", cons_valid); end
    checks++; if (cons_src !== 1'b0) begin errors++; $display("FAIL reset_cons_src: got %0b expected 0", cons_src); end
    checks++; if (wc !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", wc); end
    checks++; if ({a_ready, b_ready} !== 2'b00) begin errors++; $display("FAIL reset_readies: got %b expected 00", {a_ready, b_ready}); end
  endtask

  task automatic test_single_a;
    req_a_valid = 1'b1; req_a_data = W'(1);
    #1;
    checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL single_a_grant: got %b expected 10", {a_ready, b_ready}); end
    tick;
    req_a_valid = 1'b0; req_a_data = '1;
    #1;
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL single_a_we: got %0b expected 1", mem_we); end
    checks++; if (mem_data !== W'(1)) begin errors++; $display("FAIL single_a_data: got %h expected 1", mem_data); end
    checks++; if (cons_valid !== 1'b0) begin errors++; $display("FAIL single_a_write_cv: got %0b expected 0", cons_valid); end
    tick;
    checks++; if (cons_valid !== 1'b1) begin errors++; $display("FAIL single_a_cv: got %0b expected 1", cons_valid); end
    checks++; if (cons_src !== 1'b0) begin errors++; $display("FAIL single_a_src: got %0b expected 0", cons_src); end
    checks++; if (wc !== 16'd1) begin errors++; $display("FAIL single_a_count: got %0d expected 1", wc); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL single_a_we_full: got %0b expected 0", mem_we); end
    checks++; if (mem_data !== W'(1)) begin errors++; $display("FAIL single_a_hold: got %h expected 1", mem_data); end
    cons_ready = 1'b1;
    tick;
    cons_ready = 1'b0;
    checks++; if (cons_valid !== 1'b0) begin errors++; $display("FAIL single_a_consumed: got %0b expected 0", cons_valid); end
  endtask

  task automatic test_single_b;
    logic [W-1:0] d;
    d = {NE{32'hB5B5_0002}};
    req_b_valid = 1'b1; req_b_data = d;
    #1;
    checks++; if ({a_ready, b_ready} !== 2'b01) begin errors++; $display("FAIL single_b_grant: got %b expected 01", {a_ready, b_ready}); end
    tick;
    req_b_valid = 1'b0; req_b_data = '0;
    checks++; if (mem_data !== d) begin errors++; $display("FAIL single_b_data: got %h expected %h", mem_data, d); end
    tick;
    checks++; if (cons_src !== 1'b1) begin errors++; $display("FAIL single_b_src: got %0b expected 1", cons_src); end
    checks++; if (wc !== 16'd2) begin errors++; $display("FAIL single_b_count: got %0d expected 2", wc); end
    cons_ready = 1'b1;
    tick;
    cons_ready = 1'b0;
  endtask

  task automatic test_arbitration;
    logic [15:0] wc0;
    int grants;
    logic exp_b;
    wc0 = wc;
    grants = 0;
    req_a_valid = 1'b1; req_a_data = {NE{32'hAAAA_0003}};
    req_b_valid = 1'b1; req_b_data = {NE{32'hBBBB_0004}};
    cons_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && grants < 4; cyc++) begin
      #1;
      if (a_ready && b_ready) begin
        checks++; errors++; $display("FAIL arb_both_ready: got 11 expected at most one");
      end
      if (a_ready || b_ready) begin
`ifdef RESULT_PREV_ARB_RR_EN
        exp_b = (grants % 2 == 1);
`else
        exp_b = 1'b0;
`endif
        checks++; if (b_ready !== exp_b) begin errors++; $display("FAIL arb_grant_%0d: got b_ready=%0b expected %0b", grants, b_ready, exp_b); end
        grants++;
      end
      tick;
    end
    req_a_valid = 1'b0; req_b_valid = 1'b0;
    checks++; if (grants != 4) begin errors++; $display("FAIL arb_timeout: got %0d grants expected 4", grants); end
    tick;
    checks++; if (wc !== wc0 + 16'd4) begin errors++; $display("FAIL arb_count: got %0d expected %0d", wc, wc0 + 16'd4); end
    checks++; if (cons_valid !== 1'b1) begin errors++; $display("FAIL arb_final_cv: got %0b expected 1", cons_valid); end
    tick;
    cons_ready = 1'b0;
  endtask

  task automatic test_full_hold;
    logic [W-1:0] d, db;
    d  = {NE{32'hC0DE_0005}};
    db = {NE{32'hD00D_0006}};
    req_a_valid = 1'b1; req_a_data = d;
    tick;
    req_a_valid = 1'b0;
    tick;
    checks++; if (cons_valid !== 1'b1) begin errors++; $display("FAIL hold_enter: got %0b expected 1", cons_valid); end
    req_b_valid = 1'b1; req_b_data = db;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL hold_b_ready_%0d: got %0b expected 0", i, b_ready); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL hold_we_%0d: got %0b expected 0", i, mem_we); end
      checks++; if (mem_data !== d) begin errors++; $display("FAIL hold_data_%0d: got %h expected %h", i, mem_data, d); end
      tick;
    end
    cons_ready = 1'b1;
    #1;
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL nobypass_b_ready: got %0b expected 0", b_ready); end
    tick;
    cons_ready = 1'b0;
    #1;
    checks++; if (cons_valid !== 1'b0) begin errors++; $display("FAIL nobypass_cv: got %0b expected 0", cons_valid); end
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL nobypass_grant: got %0b expected 1", b_ready); end
    tick;
    req_b_valid = 1'b0;
    checks++; if (mem_we !== 1'b1 || mem_data !== db) begin errors++; $display("FAIL nobypass_write: got we=%0b data=%h expected we=1 data=%h", mem_we, mem_data, db); end
    tick;
    checks++; if (cons_src !== 1'b1) begin errors++; $display("FAIL nobypass_src: got %0b expected 1", cons_src); end
    cons_ready = 1'b1;
    tick;
    cons_ready = 1'b0;
  endtask

  task automatic test_reset_in_write;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    req_a_valid = 1'b1; req_a_data = {NE{32'hE0E0_0007}};
    tick;
    req_a_valid = 1'b0;
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rstw_in_write: got %0b expected 1", mem_we); end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rstw_we: got %0b expected 0", mem_we); end
    checks++; if (cons_valid !== 1'b0) begin errors++; $display("FAIL rstw_cv: got %0b expected 0", cons_valid); end
    checks++; if (wc !== 16'd0) begin errors++; $display("FAIL rstw_count: got %0d expected 0", wc); end
    tick;
    checks++; if (cons_valid !== 1'b0 || wc !== 16'd0) begin errors++; $display("FAIL rstw_after: got cv=%0b count=%0d expected cv=0 count=0", cons_valid, wc); end
  endtask

  task automatic test_wrap;
    int exp_seq[5] = '{1, 2, 3, 0, 1};
    reset = 1'b1;
    tick;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_a_valid = 1'b1; req_a_data = W'(i + 16);
      tick;
      req_a_valid = 1'b0;
      tick;
      checks++; if (wc2 !== 2'(exp_seq[i])) begin errors++; $display("FAIL wrap_%0d: got %0d expected %0d", i, wc2, exp_seq[i]); end
      cons_ready = 1'b1;
      tick;
      cons_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset;
    test_single_a;
    test_single_b;
    test_arbitration;
    test_full_hold;
    test_reset_in_write;
    test_wrap;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
